// File: rtl/hazard_ctrl_unit_if.sv
// ============================================================================
// Module      : hazard_ctrl_unit_if
// Description : Signal bundle between the pipeline controller and the
//               hazard control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_unit_if #(
   parameter int NREAD = 3,
   parameter int CNT_W = 16
);
   logic [NREAD-1:0]   match_e_m;
   logic [NREAD-1:0]   match_e_w;
   logic               match_d_e;
   logic               regwrite_m;
   logic               regwrite_w;
   logic               memtoreg_e;
   logic               pcsrc_d;
   logic               branch_taken_e;
   logic               mc_busy;

   logic [2*NREAD-1:0] forward_e;
   logic               stall_f;
   logic               stall_d;
   logic               stall_e;
   logic               flush_d;
   logic               flush_e;
   logic               flush_m;
   logic [CNT_W-1:0]   stall_cycles;

   modport master (
      output match_e_m, match_e_w, match_d_e, regwrite_m, regwrite_w,
             memtoreg_e, pcsrc_d, branch_taken_e, mc_busy,
      input  forward_e, stall_f, stall_d, stall_e, flush_d, flush_e,
             flush_m, stall_cycles
   );

   modport slave (
      input  match_e_m, match_e_w, match_d_e, regwrite_m, regwrite_w,
             memtoreg_e, pcsrc_d, branch_taken_e, mc_busy,
      output forward_e, stall_f, stall_d, stall_e, flush_d, flush_e,
             flush_m, stall_cycles
   );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
// ============================================================================
// Module      : hazard_ctrl_unit
// Description : 5-stage pipeline hazard controller: operand forwarding,
//               load-use / PC-write / multi-cycle stalls, stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl_unit #(
   parameter int NREAD     = 3,
   parameter int LOAD_LAT  = 1,
   parameter int PCW_DEPTH = 3,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   hazard_ctrl_unit_if.slave hz
);

   localparam int LD_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
   localparam logic [LD_W-1:0] C_LD_RELOAD = LD_W'(LOAD_LAT - 1);

   logic [LD_W-1:0]      ld_cnt_q, ld_cnt_d;
   logic [PCW_DEPTH-1:0] pcw_sr_q, pcw_sr_d;
   logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

   logic [2*NREAD-1:0]   w_fwd;
   logic                 w_ld_hit, w_ld_stall, w_pcw_pend, w_pcw_last, w_sr_in;
   logic                 w_stall_f, w_stall_d, w_stall_e;
   logic                 w_flush_d, w_flush_e, w_flush_m;

   // M-stage result is younger than W, so it wins when both match.
   for (genvar i = 0; i < NREAD; i++) begin : g_fwd
      assign w_fwd[2*i +: 2] = (hz.match_e_m[i] & hz.regwrite_m) ? 2'b10 :
                               (hz.match_e_w[i] & hz.regwrite_w) ? 2'b01 : 2'b00;
   end

   always_comb begin
      w_ld_hit   = hz.memtoreg_e & hz.match_d_e & (ld_cnt_q == '0);
      w_ld_stall = w_ld_hit | (ld_cnt_q != '0);
      w_pcw_pend = hz.pcsrc_d | (|pcw_sr_q[PCW_DEPTH-2:0]);
      w_pcw_last = pcw_sr_q[PCW_DEPTH-1];

      w_stall_f = 1'b0;
      w_stall_d = 1'b0;
      w_stall_e = 1'b0;
      w_flush_d = 1'b0;
      w_flush_e = 1'b0;
      w_flush_m = 1'b0;

      if (hz.branch_taken_e) begin
         w_flush_d = 1'b1;
         w_flush_e = 1'b1;
      end else if (hz.mc_busy) begin
         w_stall_f = 1'b1;
         w_stall_d = 1'b1;
         w_stall_e = 1'b1;
         w_flush_m = 1'b1;
      end else if (w_ld_stall) begin
         w_stall_f = 1'b1;
         w_stall_d = 1'b1;
         w_flush_e = 1'b1;
      end else if (w_pcw_pend) begin
         w_stall_f = 1'b1;
         w_flush_d = 1'b1;
      end else if (w_pcw_last) begin
         w_flush_d = 1'b1;
      end

      ld_cnt_d = ld_cnt_q;
      if (hz.branch_taken_e) begin
         ld_cnt_d = '0;
      end else if (!hz.mc_busy) begin
         if (w_ld_hit) begin
            ld_cnt_d = C_LD_RELOAD;
         end else if (ld_cnt_q != '0) begin
            ld_cnt_d = ld_cnt_q - 1'b1;
         end
      end

      // The F/D flush raised by the pending PC write itself must not kill
      // the writer; only a held D stage or a taken branch stops it entering E.
      w_sr_in  = hz.pcsrc_d & ~w_stall_d & ~hz.branch_taken_e;
      pcw_sr_d = pcw_sr_q;
      if (!hz.mc_busy) begin
         pcw_sr_d = {pcw_sr_q[PCW_DEPTH-2:0], w_sr_in};
      end

      stall_cnt_d = stall_cnt_q;
      if (w_stall_f && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ld_cnt_q    <= '0;
         pcw_sr_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         ld_cnt_q    <= ld_cnt_d;
         pcw_sr_q    <= pcw_sr_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // While reset is asserted the pipeline is held empty: all flushes, no stalls.
   assign hz.forward_e    = reset_n ? w_fwd : '0;
   assign hz.stall_f      = reset_n & w_stall_f;
   assign hz.stall_d      = reset_n & w_stall_d;
   assign hz.stall_e      = reset_n & w_stall_e;
   assign hz.flush_d      = ~reset_n | w_flush_d;
   assign hz.flush_e      = ~reset_n | w_flush_e;
   assign hz.flush_m      = ~reset_n | w_flush_m;
   assign hz.stall_cycles = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
// ============================================================================
// Module      : tb_hazard_ctrl_unit
// Description : Self-checking bench for hazard_ctrl_unit (vector table plus
//               multi-cycle sequences, scoreboard queue of expected outputs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl_unit;

   typedef struct packed {
      logic [2:0] mem;
      logic [2:0] mew;
      logic       mde;
      logic       rwm;
      logic       rww;
      logic       ld;
      logic       pc;
      logic       br;
      logic       busy;
   } in_t;

   typedef struct packed {
      logic [5:0] fwd;
      logic       sf;
      logic       sd;
      logic       se;
      logic       fd;
      logic       fe;
      logic       fm;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   logic clk;
   logic reset_n;

   hazard_ctrl_unit_if #(.NREAD(3), .CNT_W(16)) hz ();
   hazard_ctrl_unit_if #(.NREAD(3), .CNT_W(4))  hz4 ();

   hazard_ctrl_unit #(.NREAD(3), .LOAD_LAT(2), .PCW_DEPTH(3), .CNT_W(16)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .hz      (hz)
   );

   hazard_ctrl_unit #(.NREAD(3), .LOAD_LAT(2), .PCW_DEPTH(3), .CNT_W(4)) u_dut4 (
      .clk     (clk),
      .reset_n (reset_n),
      .hz      (hz4)
   );

   assign hz4.match_e_m      = hz.match_e_m;
   assign hz4.match_e_w      = hz.match_e_w;
   assign hz4.match_d_e      = hz.match_d_e;
   assign hz4.regwrite_m     = hz.regwrite_m;
   assign hz4.regwrite_w     = hz.regwrite_w;
   assign hz4.memtoreg_e     = hz.memtoreg_e;
   assign hz4.pcsrc_d        = hz.pcsrc_d;
   assign hz4.branch_taken_e = hz.branch_taken_e;
   assign hz4.mc_busy        = hz.mc_busy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_cnt  = '0;
   logic [3:0]  exp_cnt4 = '0;
   out_t        sb_q[$];

   function automatic in_t fi(input logic [2:0] mem, input logic [2:0] mew,
                              input logic mde, input logic rwm, input logic rww,
                              input logic ld, input logic pc, input logic br,
                              input logic busy);
      fi = '{mem: mem, mew: mew, mde: mde, rwm: rwm, rww: rww,
             ld: ld, pc: pc, br: br, busy: busy};
   endfunction

   function automatic out_t fo(input logic [5:0] fwd, input logic sf, input logic sd,
                               input logic se, input logic fd, input logic fe,
                               input logic fm);
      fo = '{fwd: fwd, sf: sf, sd: sd, se: se, fd: fd, fe: fe, fm: fm};
   endfunction

   task automatic drive(input in_t v);
      hz.match_e_m      = v.mem;
      hz.match_e_w      = v.mew;
      hz.match_d_e      = v.mde;
      hz.regwrite_m     = v.rwm;
      hz.regwrite_w     = v.rww;
      hz.memtoreg_e     = v.ld;
      hz.pcsrc_d        = v.pc;
      hz.branch_taken_e = v.br;
      hz.mc_busy        = v.busy;
   endtask

   task automatic check_out(input string tag);
      out_t a;
      out_t e;
      a = {hz.forward_e, hz.stall_f, hz.stall_d, hz.stall_e,
           hz.flush_d, hz.flush_e, hz.flush_m};
      n_tests++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s scoreboard empty, got %b", tag, a);
      end else begin
         e = sb_q.pop_front();
         if (a !== e) begin
            n_fail++;
            $display("FAIL %s outputs {fwd,sf,sd,se,fd,fe,fm} got %b want %b", tag, a, e);
         end
      end
      n_tests++;
      if (hz.stall_cycles !== exp_cnt) begin
         n_fail++;
         $display("FAIL %s stall_cycles got %0d want %0d", tag, hz.stall_cycles, exp_cnt);
      end
      n_tests++;
      if (hz4.stall_cycles !== exp_cnt4) begin
         n_fail++;
         $display("FAIL %s stall_cycles(4b) got %0d want %0d", tag, hz4.stall_cycles, exp_cnt4);
      end
   endtask

   // One pipeline cycle: drive after the edge, compare combinational outputs mid-cycle.
   task automatic apply(input in_t v, input out_t e, input string tag);
      @(posedge clk);
      #1;
      drive(v);
      sb_q.push_back(e);
      @(negedge clk);
      check_out(tag);
      if (e.sf) begin
         if (exp_cnt != 16'hFFFF) exp_cnt++;
         if (exp_cnt4 != 4'hF) exp_cnt4++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[17];
      in_t  q_i, hit_i, busy_i, br_i, pc_i;
      out_t none_o, ld_o, busy_o, br_o, pcw_o, pcl_o, rst_o;

      q_i    = fi(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      hit_i  = fi(3'b000, 3'b000, 1, 0, 0, 1, 0, 0, 0);
      busy_i = fi(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 1);
      br_i   = fi(3'b000, 3'b000, 0, 0, 0, 0, 0, 1, 0);
      pc_i   = fi(3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 0);

      none_o = fo(6'b0, 0, 0, 0, 0, 0, 0);
      ld_o   = fo(6'b0, 1, 1, 0, 0, 1, 0);
      busy_o = fo(6'b0, 1, 1, 1, 0, 0, 1);
      br_o   = fo(6'b0, 0, 0, 0, 1, 1, 0);
      pcw_o  = fo(6'b0, 1, 0, 0, 1, 0, 0);
      pcl_o  = fo(6'b0, 0, 0, 0, 1, 0, 0);
      rst_o  = fo(6'b0, 0, 0, 0, 1, 1, 1);

      tbl[0]  = '{fi(3'b011, 3'b110, 0, 1, 1, 0, 0, 0, 0), fo(6'b01_10_10, 0, 0, 0, 0, 0, 0)};
      tbl[1]  = '{fi(3'b011, 3'b110, 0, 0, 1, 0, 0, 0, 0), fo(6'b01_01_00, 0, 0, 0, 0, 0, 0)};
      tbl[2]  = '{fi(3'b011, 3'b110, 0, 1, 0, 0, 0, 0, 0), fo(6'b00_10_10, 0, 0, 0, 0, 0, 0)};
      tbl[3]  = '{fi(3'b011, 3'b110, 0, 0, 0, 0, 0, 0, 0), none_o};
      tbl[4]  = '{fi(3'b111, 3'b111, 0, 1, 1, 0, 0, 0, 0), fo(6'b10_10_10, 0, 0, 0, 0, 0, 0)};
      tbl[5]  = '{fi(3'b100, 3'b001, 0, 1, 1, 0, 0, 0, 0), fo(6'b10_00_01, 0, 0, 0, 0, 0, 0)};
      tbl[6]  = '{fi(3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 0), none_o};
      tbl[7]  = '{fi(3'b000, 3'b000, 1, 0, 0, 0, 0, 0, 0), none_o};
      tbl[8]  = '{fi(3'b001, 3'b000, 0, 1, 0, 0, 0, 0, 1), fo(6'b00_00_10, 1, 1, 1, 0, 0, 1)};
      tbl[9]  = '{fi(3'b000, 3'b000, 0, 0, 0, 0, 0, 1, 1), br_o};
      tbl[10] = '{fi(3'b000, 3'b000, 1, 0, 0, 1, 0, 1, 0), br_o};
      tbl[11] = '{fi(3'b000, 3'b000, 0, 0, 0, 0, 1, 1, 0), br_o};
      tbl[12] = '{fi(3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 1), busy_o};
      tbl[13] = '{q_i, none_o};
      tbl[14] = '{q_i, none_o};
      tbl[15] = '{q_i, none_o};
      tbl[16] = '{q_i, none_o};

      reset_n = 1'b0;
      drive(q_i);

      // Reset state: outputs gated even with hazard inputs active.
      apply(fi(3'b111, 3'b111, 1, 1, 1, 1, 1, 0, 0), rst_o, "reset0");
      apply(fi(3'b111, 3'b111, 1, 1, 1, 1, 1, 0, 1), rst_o, "reset1");
      drive(q_i);
      reset_n = 1'b1;
      apply(q_i, none_o, "post_reset");

      for (int i = 0; i < 17; i++) begin
         apply(tbl[i].i, tbl[i].o, $sformatf("vec%0d", i));
      end

      // Load-use: two bubbles.
      apply(hit_i, ld_o,   "ld_hit");
      apply(q_i,   ld_o,   "ld_2nd");
      apply(q_i,   none_o, "ld_done");
      apply(q_i,   none_o, "ld_idle");

      // PC write: three pending cycles, then the W-stage flush.
      apply(pc_i, pcw_o,  "pcw0");
      apply(q_i,  pcw_o,  "pcw1");
      apply(q_i,  pcw_o,  "pcw2");
      apply(q_i,  pcl_o,  "pcw_w");
      apply(q_i,  none_o, "pcw_done");

      // Taken branch cancels the second load bubble.
      apply(hit_i, ld_o,   "brld_hit");
      apply(br_i,  br_o,   "brld_br");
      apply(q_i,   none_o, "brld_after");

      // Multi-cycle unit freezes a pending load stall.
      apply(hit_i, ld_o, "mcld_hit");
      for (int k = 0; k < 4; k++) apply(busy_i, busy_o, $sformatf("mcld_busy%0d", k));
      apply(q_i, ld_o,   "mcld_resume");
      apply(q_i, none_o, "mcld_done");

      // Asynchronous reset while a load stall is frozen.
      apply(hit_i,  ld_o,   "rst_hit");
      apply(busy_i, busy_o, "rst_busy");
      #1;
      reset_n  = 1'b0;
      exp_cnt  = '0;
      exp_cnt4 = '0;
      #1;
      sb_q.push_back(rst_o);
      check_out("async_reset");
      drive(q_i);
      #1;
      reset_n = 1'b1;
      apply(q_i, none_o, "rel0");
      apply(q_i, none_o, "rel1");

      // Saturation of the narrow counter.
      for (int k = 0; k < 20; k++) apply(busy_i, busy_o, $sformatf("sat%0d", k));
      apply(q_i, none_o, "sat_end");
      n_tests++;
      if (hz4.stall_cycles !== 4'hF) begin
         n_fail++;
         $display("FAIL sat4 stall_cycles got %0h want f", hz4.stall_cycles);
      end
      n_tests++;
      if (hz.stall_cycles !== 16'd20) begin
         n_fail++;
         $display("FAIL sat16 stall_cycles got %0d want 20", hz.stall_cycles);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
